// File: rtl/sr_chain_pkg.sv
// Shared definitions for the board-level shift-register chain controllers
// (74LV165 reader, 74HC595 writer).
package sr_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LOW    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_FINISH = 3'd4
    } sr_state_e;

    // Elaboration-time ceil(log2(value)); value must be >= 2 to give a nonzero width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sr_div_tick.sv
// Phase timer: reloads on restart and flags the last cycle of a CLK_DIV-long phase.
module sr_div_tick
    import sr_chain_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW     = clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (restart)                div_cnt_d = RELOAD;
        else if (div_cnt_q != '0)   div_cnt_d = div_cnt_q - 1'b1;
    end

    assign tick = (div_cnt_q == '0);

endmodule

// File: rtl/chip_74lv165_reader.sv
// Master controller for a daisy chain of 74LV165 PISO registers: loads the
// chain, clocks it out bit by bit through QH and presents the captured word.
module chip_74lv165_reader
    import sr_chain_pkg::*;
#(
    parameter int unsigned N_CHIPS = 2,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 START,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [8*N_CHIPS-1:0] DATA,
    output logic                 SH_LDn,
    output logic                 SR_CLK,
    output logic                 SR_CLK_INH,
    input  logic                 QH_IN
);

    localparam int unsigned   W        = 8 * N_CHIPS;
    localparam int unsigned   BW       = clog2(W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    sr_state_e     state_q, state_d;
    logic          phase_end;
    logic          phase_restart;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  data_q, data_d;
    logic          sh_ldn_q, sh_ldn_d;
    logic          sr_clk_q, sr_clk_d;
    logic          sr_clk_inh_q, sr_clk_inh_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    assign phase_restart = (state_d != state_q);

    sr_div_tick #(.CLK_DIV(CLK_DIV)) u_div_tick (
        .clk     (CLK),
        .rst_n   (RSTn),
        .restart (phase_restart),
        .tick    (phase_end)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (START)     state_d = ST_LOAD;
            ST_LOAD:   if (phase_end) state_d = ST_LOW;
            ST_LOW:    if (phase_end) state_d = ST_HIGH;
            ST_HIGH:   if (phase_end) state_d = (bit_cnt_q == LAST_BIT) ? ST_FINISH : ST_LOW;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pins are decoded from the next state so the registered pins line up
    // with the state they belong to rather than lagging it by a cycle.
    always_comb begin
        sh_ldn_d     = 1'b1;
        sr_clk_d     = 1'b1;
        sr_clk_inh_d = 1'b1;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        case (state_d)
            ST_IDLE:   busy_d = 1'b0;
            ST_LOAD: begin
                sh_ldn_d     = 1'b0;
                sr_clk_inh_d = 1'b0;
            end
            ST_LOW: begin
                sr_clk_d     = 1'b0;
                sr_clk_inh_d = 1'b0;
            end
            ST_HIGH:   sr_clk_inh_d = 1'b0;
            ST_FINISH: done_d = 1'b1;
            default:   busy_d = 1'b0;
        endcase
    end

    // QH is sampled at the end of the low half, just before the rising edge shifts the chain.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        if (state_q == ST_IDLE && state_d == ST_LOAD) bit_cnt_d = '0;
        if (state_q == ST_HIGH && phase_end)          bit_cnt_d = bit_cnt_q + 1'b1;
        if (state_q == ST_LOW && phase_end)           shreg_d   = {shreg_q[W-2:0], QH_IN};
        if (state_d == ST_FINISH)                     data_d    = shreg_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            sh_ldn_q     <= 1'b1;
            sr_clk_q     <= 1'b1;
            sr_clk_inh_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            sh_ldn_q     <= sh_ldn_d;
            sr_clk_q     <= sr_clk_d;
            sr_clk_inh_q <= sr_clk_inh_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign DATA       = data_q;
    assign SH_LDn     = sh_ldn_q;
    assign SR_CLK     = sr_clk_q;
    assign SR_CLK_INH = sr_clk_inh_q;

endmodule
